pixel_tap_sampler: RTL and testbench

- Upstream stage of the frequency analyzer manager; runs in the pixel clock domain.
- Watches the 8-bit line-scan pixel stream and extracts three tap pixels per line at fixed indices.
- Thresholds each tap pixel to one bit and debounces it across consecutive lines.
- Presents three clean binary sample signals (plus per-line strobes and status) to the per-pixel frequency analyzers.

---
 rtl/pixel_tap_pkg.sv | 18 +
 rtl/tap_filter.sv | 62 ++++++
 rtl/pixel_tap_sampler.sv | 172 +++++++++++++++++
 tb/tb_pixel_tap_sampler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_tap_pkg.sv
// Shared types and constants for the pixel tap sampler and its per-tap filters.
package pixel_tap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        CAPTURE
    } state_t;

    localparam int TAP_COUNT    = 3;
    localparam int LINE_COUNT_W = 16;
    localparam int FILT_CNT_W   = 4;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tap_filter.sv
// One tap: thresholds the selected pixel value and debounces the resulting bit across lines.
module tap_filter
    import pixel_tap_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int LIMIT        = 128,
    parameter int FILTER_DEPTH = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic              i_index_match,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_sample,
    output logic              o_strobe
);
    localparam logic [DATA_W:0]       LIMIT_V  = (DATA_W + 1)'(LIMIT);
    localparam logic [FILT_CNT_W-1:0] LAST_CNT = FILT_CNT_W'(FILTER_DEPTH - 1);

    if (FILTER_DEPTH < 1 || FILTER_DEPTH > 15) begin : g_bad_depth
        $error("tap_filter: FILTER_DEPTH must be in 1..15");
    end

    logic                  w_take;
    logic                  w_raw;
    logic                  r_sample;
    logic                  r_strobe;
    logic [FILT_CNT_W-1:0] r_cnt;

    assign w_take = i_capture & i_index_match;
    assign w_raw  = ({1'b0, i_value} >= LIMIT_V);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 1'b0;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
        end else if (i_clear) begin
            r_sample <= 1'b0;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_strobe <= w_take;
            if (w_take) begin
                if (w_raw == r_sample) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST_CNT) begin
                    r_sample <= ~r_sample;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + FILT_CNT_W'(1);
                end
            end
        end
    end

    assign o_sample = r_sample;
    assign o_strobe = r_strobe;

endmodule

// File: rtl/pixel_tap_sampler.sv
// Line-scan tap sampler: tracks pixel position per line and feeds three debounced tap filters.
// Build macro PIXEL_TAP_WINDOW_EN: each tap thresholds the 3-pixel sum around its index.
module pixel_tap_sampler
    import pixel_tap_pkg::*;
#(
    parameter int PIXEL0_INDEX = 15,
    parameter int PIXEL1_INDEX = 511,
    parameter int PIXEL2_INDEX = 1023,
    parameter int LINE_LENGTH  = 1024,
    parameter int THRESHOLD    = 128,
    parameter int FILTER_DEPTH = 3
)(
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic [7:0]              data,
    input  logic                    data_valid,
    input  logic                    line_start,
    input  logic                    enable,
    input  logic                    clear,
    output logic [TAP_COUNT-1:0]    sample_data,
    output logic [TAP_COUNT-1:0]    sample_strobe,
    output logic                    line_done,
    output logic [LINE_COUNT_W-1:0] line_count,
    output logic                    line_error
);
    localparam int               CNT_W    = cnt_width(LINE_LENGTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LENGTH - 1);
    localparam int TAP_IDX [TAP_COUNT] = '{PIXEL0_INDEX, PIXEL1_INDEX, PIXEL2_INDEX};
`ifdef PIXEL_TAP_WINDOW_EN
    localparam int VAL_W = 10;
    localparam int WIN   = 1;
    localparam int LIMIT = 3 * THRESHOLD;
`else
    localparam int VAL_W = 8;
    localparam int WIN   = 0;
    localparam int LIMIT = THRESHOLD;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_pix_cnt;
    logic [CNT_W-1:0]        w_pix_idx;
    logic                    r_line_done;
    logic                    r_line_error;
    logic                    r_after_line;
    logic [LINE_COUNT_W-1:0] r_line_count;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_short;
    logic                    w_long;
    logic [VAL_W-1:0]        w_tap_value;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pix_idx   = r_pix_cnt;
        w_accept    = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = WAIT_LINE;
            WAIT_LINE: begin
                if (data_valid) begin
                    if (line_start) begin
                        w_accept  = 1'b1;
                        w_pix_idx = '0;
                    end else begin
                        w_long = r_after_line;
                    end
                end
            end
            CAPTURE: begin
                if (data_valid) begin
                    w_accept = 1'b1;
                    if (line_start) begin
                        w_short   = 1'b1;
                        w_pix_idx = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) w_state_nxt = (w_pix_idx == LAST_IDX) ? WAIT_LINE : CAPTURE;
        // Dropping enable abandons the line without touching filter state.
        if (!enable) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_short     = 1'b0;
            w_long      = 1'b0;
        end
        w_last = w_accept && (w_pix_idx == LAST_IDX);
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pix_cnt    <= '0;
            r_line_done  <= 1'b0;
            r_line_count <= '0;
            r_line_error <= 1'b0;
            r_after_line <= 1'b0;
        end else if (clear) begin
            r_state      <= IDLE;
            r_pix_cnt    <= '0;
            r_line_done  <= 1'b0;
            r_line_count <= '0;
            r_line_error <= 1'b0;
            r_after_line <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_line_done <= w_last;
            if (w_accept) r_pix_cnt <= w_last ? '0 : w_pix_idx + CNT_W'(1);
            if (w_last) r_line_count <= r_line_count + LINE_COUNT_W'(1);
            if (w_short || w_long) r_line_error <= 1'b1;
            if (w_last) begin
                r_after_line <= 1'b1;
            end else if (w_accept || w_state_nxt == IDLE) begin
                r_after_line <= 1'b0;
            end
        end
    end

`ifdef PIXEL_TAP_WINDOW_EN
    logic [7:0] r_prev1;
    logic [7:0] r_prev2;

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_prev1 <= '0;
            r_prev2 <= '0;
        end else if (clear) begin
            r_prev1 <= '0;
            r_prev2 <= '0;
        end else if (w_accept) begin
            r_prev1 <= data;
            r_prev2 <= r_prev1;
        end
    end

    assign w_tap_value = VAL_W'(r_prev2) + VAL_W'(r_prev1) + VAL_W'(data);
`else
    assign w_tap_value = data;
`endif

    for (genvar k = 0; k < TAP_COUNT; k++) begin : g_tap
        localparam int MATCH_IDX = TAP_IDX[k] + WIN;

        if (TAP_IDX[k] < WIN || TAP_IDX[k] > LINE_LENGTH - 1 - WIN) begin : g_bad_index
            $error("pixel_tap_sampler: tap index out of range for LINE_LENGTH");
        end

        tap_filter #(
            .DATA_W       (VAL_W),
            .LIMIT        (LIMIT),
            .FILTER_DEPTH (FILTER_DEPTH)
        ) u_tap (
            .clk           (pixel_clock),
            .rst           (reset),
            .i_clear       (clear),
            .i_capture     (w_accept),
            .i_index_match (w_pix_idx == CNT_W'(MATCH_IDX)),
            .i_value       (w_tap_value),
            .o_sample      (sample_data[k]),
            .o_strobe      (sample_strobe[k])
        );
    end

    assign line_done  = r_line_done;
    assign line_count = r_line_count;
    assign line_error = r_line_error;

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Scoreboard bench for pixel_tap_sampler: a behavioural line model predicts strobes and line ends.
module tb_pixel_tap_sampler;
    localparam int LINE_LENGTH  = 1024;
    localparam int THRESHOLD    = 128;
    localparam int FILTER_DEPTH = 3;
`ifdef PIXEL_TAP_WINDOW_EN
    localparam int WIN = 1;
    localparam int P2  = 1022;
`else
    localparam int WIN = 0;
    localparam int P2  = 1023;
`endif
    localparam int TAP_IDX [3] = '{15, 511, P2};

    typedef struct {
        int tap;
        int sample;
    } strobe_exp_t;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        data_valid;
    logic        line_start;
    logic        enable;
    logic        clear;
    logic [2:0]  sample_data;
    logic [2:0]  sample_strobe;
    logic        line_done;
    logic [15:0] line_count;
    logic        line_error;

    strobe_exp_t sb_q[$];
    int          ld_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    bit m_idle, m_cap, m_after, m_err;
    int m_idx, m_count, m_h1, m_h2;
    int m_sample [3];
    int m_fcnt   [3];

    pixel_tap_sampler #(
        .PIXEL0_INDEX (15),
        .PIXEL1_INDEX (511),
        .PIXEL2_INDEX (P2),
        .LINE_LENGTH  (LINE_LENGTH),
        .THRESHOLD    (THRESHOLD),
        .FILTER_DEPTH (FILTER_DEPTH)
    ) dut (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .data          (data),
        .data_valid    (data_valid),
        .line_start    (line_start),
        .enable        (enable),
        .clear         (clear),
        .sample_data   (sample_data),
        .sample_strobe (sample_strobe),
        .line_done     (line_done),
        .line_count    (line_count),
        .line_error    (line_error)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_idle  = 1'b1;
        m_cap   = 1'b0;
        m_after = 1'b0;
        m_err   = 1'b0;
        m_idx   = 0;
        m_count = 0;
        m_h1    = 0;
        m_h2    = 0;
        for (int k = 0; k < 3; k++) begin
            m_sample[k] = 0;
            m_fcnt[k]   = 0;
        end
    endfunction

    // Drive one clock of input and advance the model by the same pixel.
    task automatic cycle(input bit valid, input bit ls, input int v);
        bit acc;
        bit raw;
        data       = 8'(v);
        data_valid = valid;
        line_start = ls;
        acc        = 1'b0;
        if (!enable) begin
            m_idle  = 1'b1;
            m_cap   = 1'b0;
            m_after = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (valid) begin
            if (ls) begin
                if (m_cap) m_err = 1'b1;
                m_cap = 1'b1;
                m_idx = 0;
                acc   = 1'b1;
            end else if (m_cap) begin
                acc = 1'b1;
            end else if (m_after) begin
                m_err = 1'b1;
            end
            if (acc) begin
                m_after = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (m_idx == TAP_IDX[k] + WIN) begin
                        raw = (WIN != 0) ? (m_h2 + m_h1 + v >= 3 * THRESHOLD) : (v >= THRESHOLD);
                        if (int'(raw) == m_sample[k]) begin
                            m_fcnt[k] = 0;
                        end else begin
                            m_fcnt[k]++;
                            if (m_fcnt[k] == FILTER_DEPTH) begin
                                m_sample[k] = 1 - m_sample[k];
                                m_fcnt[k]   = 0;
                            end
                        end
                        sb_q.push_back('{tap: k, sample: m_sample[k]});
                    end
                end
                m_h2 = m_h1;
                m_h1 = v;
                if (m_idx == LINE_LENGTH - 1) begin
                    m_count = (m_count + 1) % 65536;
                    ld_q.push_back(m_count);
                    m_cap   = 1'b0;
                    m_after = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge pixel_clock);
        #1;
        data_valid = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    // Pixels 0..len-1 with line_start on pixel 0; each tap's neighbourhood carries its value.
    task automatic send_line(input int len, input int v0, input int v1, input int v2);
        int vals [3];
        int v;
        vals = '{v0, v1, v2};
        for (int i = 0; i < len; i++) begin
            v = 0;
            for (int k = 0; k < 3; k++)
                if (i >= TAP_IDX[k] - WIN && i <= TAP_IDX[k] + WIN) v = vals[k];
            cycle(1'b1, i == 0, v);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge pixel_clock);
        #1;
        clear = 1'b0;
        model_reset();
        check("clear_count", line_count, 0);
        check("clear_sample", sample_data, 0);
    endtask

    always @(negedge pixel_clock) begin
        strobe_exp_t e;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (sample_strobe[k]) begin
                    check("strobe_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("strobe_tap", k, e.tap);
                        check("strobe_sample", sample_data[k], e.sample);
                    end
                end
            end
            if (line_done) begin
                check("line_done_expected", ld_q.size() > 0, 1);
                if (ld_q.size() > 0) check("line_done_count", line_count, ld_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        enable     = 1'b0;
        data       = '0;
        data_valid = 1'b0;
        line_start = 1'b0;
        model_reset();
        repeat (3) @(posedge pixel_clock);
        #1;
        check("rst_sample_data", sample_data, 0);
        check("rst_strobe", sample_strobe, 0);
        check("rst_line_done", line_done, 0);
        check("rst_line_count", line_count, 0);
        check("rst_line_error", line_error, 0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(2);

        // Sustained high tap 0 flips after exactly FILTER_DEPTH lines.
        for (int n = 0; n < 3; n++) begin
            send_line(LINE_LENGTH, 200, 0, 0);
            if (n == 1) check("t1_sample_after_2", sample_data[0], 0);
        end
        idle(3);
        check("t1_sample0", sample_data[0], 1);
        check("t1_sample_hi", sample_data[2:1], 0);
        check("t1_count", line_count, 3);
        check("t1_error", line_error, 0);

        // Alternating raw values around the threshold never accumulate.
        send_line(LINE_LENGTH, 127, 0, 0);
        send_line(LINE_LENGTH, 128, 0, 0);
        send_line(LINE_LENGTH, 50, 0, 0);
        send_line(LINE_LENGTH, 200, 0, 0);
        idle(3);
        check("t2_sample0", sample_data[0], 1);
        check("t2_count", line_count, 7);

        // Short line: restart at pixel 600.
        do_clear();
        idle(2);
        send_line(600, 0, 200, 200);
        check("t3_error_before", line_error, 0);
        send_line(LINE_LENGTH, 0, 200, 200);
        idle(3);
        check("t3_error", line_error, 1);
        check("t3_count", line_count, 1);
        check("t3_sample", sample_data, 0);

        // Long line: data keeps flowing past the last pixel.
        do_clear();
        idle(2);
        send_line(LINE_LENGTH, 0, 0, 0);
        check("t4_error_at_end", line_error, 0);
        check("t4_count_at_end", line_count, 1);
        cycle(1'b1, 1'b0, 0);
        check("t4_error_long", line_error, 1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 200);
        idle(3);
        check("t4_count_after", line_count, 1);

        // Enable dropped mid-line: partial line discarded.
        do_clear();
        idle(2);
        send_line(300, 200, 0, 0);
        enable = 1'b0;
        cycle(1'b1, 1'b0, 0);
        enable = 1'b1;
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 200);
        idle(3);
        check("t5_count_partial", line_count, 0);
        check("t5_error_partial", line_error, 0);
        check("t5_sample_partial", sample_data, 0);
        send_line(LINE_LENGTH, 0, 0, 0);
        idle(3);
        check("t5_count", line_count, 1);
        check("t5_sample", sample_data, 0);

`ifdef PIXEL_TAP_WINDOW_EN
        // Window sums 390 (above 384) then 380 (below).
        do_clear();
        idle(2);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < LINE_LENGTH; i++)
                cycle(1'b1, i == 0, (i == 14) ? 100 : (i == 15) ? 150 : (i == 16) ? ((n < 3) ? 140 : 130) : 0);
            idle(2);
            if (n == 2) check("win_sample_high", sample_data[0], 1);
        end
        check("win_sample_low", sample_data[0], 0);
`endif

        idle(5);
        check("sb_strobes_drained", sb_q.size(), 0);
        check("sb_lines_drained", ld_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
